// File: rtl/chardisp_pkg.sv
// Shared types and geometry for the character-display VRAM writer.
// Holds the command opcodes, FSM states, default screen size and field widths.
package chardisp_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;
  localparam int XW       = 7;
  localparam int YW       = 5;
  localparam int CELLW    = 16;

  typedef enum logic [1:0] {
    OP_PUT     = 2'b00,
    OP_CLEAR   = 2'b01,
    OP_SETPOS  = 2'b10,
    OP_NEWLINE = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/chardisp_cursor.sv
// Cursor position plus an incrementally maintained row base, so the cell
// address is row_base + x and no multiplier is needed.
module chardisp_cursor
  import chardisp_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int AW   = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          newline,
  input  logic          load,
  input  logic [XW-1:0] load_x,
  input  logic [YW-1:0] load_y,
  input  logic          zero,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [AW-1:0] addr
);

  localparam logic [XW-1:0] X_MAX  = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(ROWS - 1);
  localparam logic [AW-1:0] COLS_A = AW'(COLS);

  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;
  logic [AW-1:0] base_reg;
  logic [XW-1:0] clamp_x;
  logic [YW-1:0] clamp_y;
  logic          x_last;
  logic          y_last;

  // Constant row-start table, only consulted when the cursor is loaded.
  logic [AW-1:0] row_tbl [2**YW];
  generate
    for (genvar gi = 0; gi < 2**YW; gi++) begin : g_row
      assign row_tbl[gi] = (gi < ROWS) ? AW'(gi * COLS) : '0;
    end
  endgenerate

  always_comb begin
    clamp_x = (load_x > X_MAX) ? X_MAX : load_x;
    clamp_y = (load_y > Y_MAX) ? Y_MAX : load_y;
    x_last  = (x_reg == X_MAX);
    y_last  = (y_reg == Y_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg    <= '0;
      y_reg    <= '0;
      base_reg <= '0;
    end else if (zero) begin
      x_reg    <= '0;
      y_reg    <= '0;
      base_reg <= '0;
    end else if (load) begin
      x_reg    <= clamp_x;
      y_reg    <= clamp_y;
      base_reg <= row_tbl[clamp_y];
    end else if ((advance && x_last) || newline) begin
      x_reg <= '0;
      if (y_last) begin
        y_reg    <= '0;
        base_reg <= '0;
      end else begin
        y_reg    <= y_reg + YW'(1);
        base_reg <= base_reg + COLS_A;
      end
    end else if (advance) begin
      x_reg <= x_reg + XW'(1);
    end
  end

  assign x    = x_reg;
  assign y    = y_reg;
  assign addr = base_reg + AW'(x_reg);

endmodule

// File: rtl/chardisp_vram_writer.sv
// Turns PUT/CLEAR/SETPOS/NEWLINE commands into registered VRAM cell writes.
// CLEAR sweeps every cell one per cycle, reusing vram_addr as the sweep counter.
module chardisp_vram_writer
  import chardisp_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int AW   = 12
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [15:0]      cmd_data,
  output logic             vram_we,
  output logic [AW-1:0]    vram_addr,
  output logic [CELLW-1:0] vram_wdata,
  output logic             busy,
  output logic [XW-1:0]    cursor_x,
  output logic [YW-1:0]    cursor_y
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(COLS * ROWS - 1);

  state_e           state_reg, state_next;
  logic             we_reg, we_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [CELLW-1:0] wdata_reg, wdata_next;
  logic             adv, nl, ld, zero;
  logic             accept;
  logic [AW-1:0]    cur_addr;

  chardisp_cursor #(
    .COLS(COLS),
    .ROWS(ROWS),
    .AW  (AW)
  ) u_cursor (
    .clk    (ACLK),
    .rst    (ARESET),
    .advance(adv),
    .newline(nl),
    .load   (ld),
    .load_x (cmd_data[6:0]),
    .load_y (cmd_data[12:8]),
    .zero   (zero),
    .x      (cursor_x),
    .y      (cursor_y),
    .addr   (cur_addr)
  );

  // Ready follows state (and reset) only, never cmd_valid.
  assign cmd_ready = (state_reg == ST_IDLE) && !ARESET;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_reg == ST_CLEAR);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    adv        = 1'b0;
    nl         = 1'b0;
    ld         = 1'b0;
    zero       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(cmd_op))
            OP_PUT: begin
              adv        = 1'b1;
              we_next    = 1'b1;
              addr_next  = cur_addr;
              wdata_next = cmd_data;
            end
            OP_CLEAR: begin
              state_next = ST_CLEAR;
              we_next    = 1'b1;
              addr_next  = '0;
              wdata_next = cmd_data;
            end
            OP_SETPOS:  ld = 1'b1;
            OP_NEWLINE: nl = 1'b1;
            default: ;
          endcase
        end
      end
      ST_CLEAR: begin
        // The final cell is on the bus this cycle; leave and home the cursor.
        if (addr_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
          zero       = 1'b1;
        end else begin
          we_next   = 1'b1;
          addr_next = addr_reg + AW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign vram_we    = we_reg;
  assign vram_addr  = addr_reg;
  assign vram_wdata = wdata_reg;

endmodule

// File: tb/tb_chardisp_vram_writer.sv
// Self-checking bench: command vector table with expected cursor/writes, a
// scoreboard of due VRAM writes, and hand-written CLEAR / reset / NEWLINE runs.
module tb_chardisp_vram_writer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        vram_we;
  logic [11:0] vram_addr;
  logic [15:0] vram_wdata;
  logic        busy;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;

  chardisp_vram_writer #(.COLS(80), .ROWS(30), .AW(12)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_wdata(vram_wdata),
    .busy      (busy),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic        wr;
    logic [11:0] addr;
    logic [6:0]  x;
    logic [4:0]  y;
  } vec_t;
  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard on its due cycle.
  always @(negedge ACLK) begin
    if (ARESET === 1'b0) begin
      if (vram_we === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", vram_addr, vram_wdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (vram_addr !== e.addr || vram_wdata !== e.data || cyc != e.due) begin
            bad++;
            $display("FAIL write: got addr=%0d data=%0h cyc=%0d expected addr=%0d data=%0h cyc=%0d",
                     vram_addr, vram_wdata, cyc, e.addr, e.data, e.due);
          end else if (e.addr < 3 || e.addr > 2396 || e.data != 16'h0020) begin
            $display("ok   write addr=%0d data=%0h cyc=%0d", vram_addr, vram_wdata, cyc);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        total++;
        bad++;
        e = sb.pop_front();
        $display("FAIL missing_write: got we=0 expected addr=%0d data=%0h at cyc=%0d", e.addr, e.data, e.due);
      end
    end
  end

  task automatic send1(input logic [1:0] op, input logic [15:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  int n, busy_n, rdy_hi, acc, wr_seen;

  initial begin
    vecs[0]  = '{2'b00, 16'h0741, 1'b1, 12'd0,    7'd1,  5'd0};
    vecs[1]  = '{2'b10, 16'h004F, 1'b0, 12'd0,    7'd79, 5'd0};
    vecs[2]  = '{2'b00, 16'h1111, 1'b1, 12'd79,   7'd0,  5'd1};
    vecs[3]  = '{2'b00, 16'h2222, 1'b1, 12'd80,   7'd1,  5'd1};
    vecs[4]  = '{2'b00, 16'h3333, 1'b1, 12'd81,   7'd2,  5'd1};
    vecs[5]  = '{2'b10, 16'h1D4F, 1'b0, 12'd0,    7'd79, 5'd29};
    vecs[6]  = '{2'b00, 16'h4444, 1'b1, 12'd2399, 7'd0,  5'd0};
    vecs[7]  = '{2'b10, 16'h1F7F, 1'b0, 12'd0,    7'd79, 5'd29};
    vecs[8]  = '{2'b11, 16'h9999, 1'b0, 12'd0,    7'd0,  5'd0};
    vecs[9]  = '{2'b10, 16'h0305, 1'b0, 12'd0,    7'd5,  5'd3};
    vecs[10] = '{2'b00, 16'h5555, 1'b1, 12'd245,  7'd6,  5'd3};
    vecs[11] = '{2'b11, 16'h0000, 1'b0, 12'd0,    7'd0,  5'd4};
    vecs[12] = '{2'b00, 16'hAAAA, 1'b1, 12'd320,  7'd1,  5'd4};

    ARESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 16'h0000;
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_we", vram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_cursor", {cursor_y, cursor_x}, 0);
    repeat (3) @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("rel_ready", cmd_ready, 1);

    // Table-driven commands, issued back-to-back.
    @(negedge ACLK);
    for (int i = 0; i < NV; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = vecs[i].op;
      cmd_data  = vecs[i].data;
      chk($sformatf("vec%0d_ready", i), cmd_ready, 1);
      if (vecs[i].wr) sb.push_back('{vecs[i].addr, vecs[i].data, cyc + 1});
      @(negedge ACLK);
      chk($sformatf("vec%0d_x", i), cursor_x, vecs[i].x);
      chk($sformatf("vec%0d_y", i), cursor_y, vecs[i].y);
    end
    cmd_valid = 1'b0;

    // NEWLINE held for five cycles from row 27 wraps to row 2.
    send1(2'b10, 16'h1B0A);
    chk("nl_setpos", {cursor_y, cursor_x}, {5'd27, 7'd10});
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_data  = 16'h0000;
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      if (cmd_ready) acc++;
      @(negedge ACLK);
    end
    cmd_valid = 1'b0;
    chk("nl_accepts", acc, 5);
    chk("nl_cursor", {cursor_y, cursor_x}, {5'd2, 7'd0});

    // Full CLEAR sweep.
    send1(2'b10, 16'h0907);
    chk("clr_pre_cursor", {cursor_y, cursor_x}, {5'd9, 7'd7});
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 16'h0020;
    for (int i = 0; i < 2400; i++) sb.push_back('{12'(i), 16'h0020, cyc + 1 + i});
    @(negedge ACLK);
    cmd_valid = 1'b0;
    busy_n = 0;
    rdy_hi = 0;
    n      = 0;
    while (busy && n < 3000) begin
      busy_n++;
      if (cmd_ready) rdy_hi++;
      @(negedge ACLK);
      n++;
    end
    chk("clr_busy_cycles", busy_n, 2400);
    chk("clr_ready_high_cycles", rdy_hi, 0);
    chk("clr_done_ready", cmd_ready, 1);
    chk("clr_done_cursor", {cursor_y, cursor_x}, 0);
    chk("clr_sb_empty", sb.size(), 0);

    // CLEAR aborted by reset after 100 writes.
    send1(2'b10, 16'h0403);
    chk("abort_pre_cursor", {cursor_y, cursor_x}, {5'd4, 7'd3});
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 16'h0F00;
    for (int i = 0; i < 2400; i++) sb.push_back('{12'(i), 16'h0F00, cyc + 1 + i});
    @(negedge ACLK);
    cmd_valid = 1'b0;
    repeat (99) @(negedge ACLK);
    chk("abort_100th_addr", vram_addr, 99);
    #2;
    ARESET = 1'b1;
    #1;
    sb.delete();
    chk("abort_we", vram_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", vram_addr, 0);
    chk("abort_wdata", vram_wdata, 0);
    chk("abort_ready", cmd_ready, 0);
    chk("abort_cursor", {cursor_y, cursor_x}, 0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    chk("abort_rel_ready", cmd_ready, 1);
    wr_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge ACLK);
      if (vram_we) wr_seen++;
    end
    chk("abort_no_writes", wr_seen, 0);
    chk("abort_busy_after", busy, 0);
    chk("abort_cursor_after", {cursor_y, cursor_x}, 0);
    chk("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chardisp_vram_writer.md
CHARDISP_VRAM_WRITER -- requirements
Module: chardisp_vram_writer

Interface
REQ-001 Parameter COLS, default 80, characters per row.
REQ-002 Parameter ROWS, default 30, rows per screen.
REQ-003 Parameter AW, default 12, VRAM address width; COLS*ROWS SHALL be at most 2**AW.
REQ-004 ACLK  in  1  sole clock; all state SHALL change on the rising edge.
REQ-005 ARESET  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command offered by the AXI4-Lite register bank.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high on a rising edge.
REQ-008 cmd_op  in  2  operation: 00 PUT, 01 CLEAR, 10 SETPOS, 11 NEWLINE.
REQ-009 cmd_data  in  16  PUT/CLEAR: cell value (char [7:0], attribute [15:8]); SETPOS: x [6:0], y [12:8].
REQ-010 vram_we  out  1  VRAM write strobe, one cycle per cell.
REQ-011 vram_addr  out  AW  cell address, equal to y*COLS+x.
REQ-012 vram_wdata  out  16  cell value.
REQ-013 busy  out  1  high while a CLEAR sweep is in progress.
REQ-014 cursor_x  out  7  current column, and cursor_y  out  5  current row.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and CLEAR; busy SHALL equal (state==CLEAR).
REQ-016 cmd_ready SHALL be high in IDLE and low in CLEAR; it SHALL NOT depend combinationally on cmd_valid.
REQ-017 PUT accepted at edge N: vram_we=1, vram_addr=y*COLS+x of the pre-advance cursor, and vram_wdata=cmd_data SHALL all be registered and visible in cycle N+1 only.
REQ-018 PUT advance: x+1; at x=COLS-1, x=0 and y+1; at the last cell, x=0 and y=0.
REQ-019 Back-to-back PUTs SHALL sustain one write per cycle with no bubbles.
REQ-020 SETPOS SHALL load the cursor, clamping x to COLS-1 and y to ROWS-1, and SHALL NOT write VRAM.
REQ-021 NEWLINE SHALL set x=0 and y+1, with y wrapping from ROWS-1 to 0; it SHALL NOT write VRAM.
REQ-022 CLEAR accepted at edge N: state=CLEAR; writes to addresses 0..COLS*ROWS-1 SHALL occur one per cycle from cycle N+1, all carrying the latched cmd_data.
REQ-023 After the write to the final address, the FSM SHALL return to IDLE and the cursor SHALL be set to (0,0), with cmd_ready high on the following cycle.
REQ-024 The address SHALL be produced from an incrementally maintained row base (adds only); no multiplier SHALL be inferred.
REQ-025 vram_we SHALL be low whenever no write is scheduled; vram_addr and vram_wdata SHALL hold their last values.

Reset
REQ-026 ARESET high SHALL immediately force state=IDLE, vram_we=0, vram_addr=0, vram_wdata=0, cursor=(0,0), and busy=0; cmd_ready SHALL be 0 while ARESET is high and 1 in the first cycle after release.
REQ-027 ARESET asserted mid-CLEAR SHALL abort the sweep with no further writes; a CLEAR is not resumed after release.

Structure
REQ-028 Package chardisp_pkg SHALL hold the op enum (PUT/CLEAR/SETPOS/NEWLINE), the COLS/ROWS defaults, and the x/y/cell widths.
REQ-029 Cursor and row-base tracking SHALL live in one sub-module, chardisp_cursor (advance, newline, load-clamped, and zero controls).
REQ-030 The register-bank-to-command mapping is outside this block.

Verification
REQ-031 Reset, then PUT 0x0741 -> one cycle later: vram_we=1, addr=0, wdata=0x0741; cursor=(1,0).
REQ-032 SETPOS x=79,y=0, then three back-to-back PUTs -> consecutive writes at addr 79, 80, 81; cursor=(2,1).
REQ-033 SETPOS x=79,y=29, then PUT -> write at addr 2399; cursor=(0,0). SETPOS x=127,y=31 -> cursor clamped to (79,29).
REQ-034 CLEAR 0x0020 -> exactly 2400 writes (addr 0..2399, wdata 0x0020) on consecutive cycles; busy high for 2400 cycles; cmd_ready low throughout.
REQ-035 CLEAR, then ARESET after 100 writes -> vram_we=0 in the same cycle; after release: IDLE, cursor (0,0), no further writes.
REQ-036 At y=29, NEWLINE -> cursor (0,0) and no VRAM write; op 11 while cmd_valid is held high for 5 cycles -> 5 accepts and y advances by 5 modulo 30.
